// File: rtl/alu_seq_core_if.sv
// Request/response bundle for alu_seq_core: operands and start in, result and flags out.
interface alu_seq_core_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, result_hi, carry, zero, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, result_hi, carry, zero, ovf
  );
endinterface

// File: rtl/alu_seq_core.sv
// Registered ALU with start/busy/done handshake; iterative shift-add MUL and restoring DIV.
// Define ALU_SAT_EN to make ADD/SUB saturate instead of wrapping.
module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_core_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_EXEC1, S_ITER, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rhi_q, rhi_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             v_q, v_d;

  logic [WIDTH:0]   add_s, sub_s, shl_s;
  logic [WIDTH-1:0] s1_res;
  logic             s1_c, s1_v;
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rhi_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rhi_q   <= rhi_d;
      c_q     <= c_d;
      z_q     <= z_d;
      v_q     <= v_d;
    end
  end

  // Single-cycle datapath; the extra top bit of each sum carries carry/borrow/shift-out.
  always_comb begin
    add_s  = {1'b0, a_q} + {1'b0, b_q};
    sub_s  = {1'b0, a_q} - {1'b0, b_q};
    shl_s  = {1'b0, a_q} << b_q[SHW-1:0];
    s1_res = '0;
    s1_c   = 1'b0;
    s1_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        s1_res = add_s[WIDTH-1:0];
        s1_c   = add_s[WIDTH];
        s1_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (add_s[WIDTH]) s1_res = '1;
`endif
      end
      OP_SUB: begin
        s1_res = sub_s[WIDTH-1:0];
        s1_c   = sub_s[WIDTH];
        s1_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_s[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (sub_s[WIDTH]) s1_res = '0;
`endif
      end
      OP_AND: s1_res = a_q & b_q;
      OP_OR:  s1_res = a_q | b_q;
      OP_XOR: s1_res = a_q ^ b_q;
      OP_SHL: begin
        s1_res = shl_s[WIDTH-1:0];
        s1_c   = shl_s[WIDTH];
      end
      default: ;
    endcase
  end

  // Iteration datapath: hi/lo act as {acc, multiplier} for MUL and {remainder, dividend} for DIV.
  always_comb begin
    mul_add = lo_q[0] ? a_q : {WIDTH{1'b0}};
    mul_sum = {1'b0, hi_q} + {1'b0, mul_add};
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, b_q};
    div_sub = div_sh[WIDTH-1:0] - b_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rhi_d   = rhi_q;
    c_d     = c_q;
    z_d     = z_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = (bus.op == OP_MUL) ? bus.b : bus.a;
          state_d = (bus.op[2:1] == 2'b11) ? S_ITER : S_EXEC1;
        end
      end
      S_EXEC1: begin
        res_d   = s1_res;
        rhi_d   = '0;
        c_d     = s1_c;
        z_d     = (s1_res == '0);
        v_d     = s1_v;
        state_d = S_DONE;
      end
      S_ITER: begin
        if (cnt_q == CW'(WIDTH)) begin
          c_d     = 1'b0;
          state_d = S_DONE;
          if (op_q == OP_MUL) begin
            res_d = lo_q;
            rhi_d = hi_q;
            z_d   = (lo_q == '0) && (hi_q == '0);
            v_d   = 1'b0;
          end else if (b_q == '0) begin
            res_d = '1;
            rhi_d = a_q;
            z_d   = 1'b0;
            v_d   = 1'b1;
          end else begin
            res_d = lo_q;
            rhi_d = hi_q;
            z_d   = (lo_q == '0);
            v_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_q == OP_MUL) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.result_hi = rhi_q;
  assign bus.carry     = c_q;
  assign bus.zero      = z_q;
  assign bus.ovf       = v_q;
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, registered successor to the team's 3-bit/2-bit combinational ALU wrapper.
- Full-width A/B operands, start/busy/done handshake, registered flags.
- Multi-cycle shift-add multiply and restoring divide.
- Sits behind the top-level pin wrapper; the wrapper serialises operands from ui_in and presents result/flags on uo_out.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 4..16).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  operation select, captured with start.
- a  input  WIDTH  operand A, captured with start.
- b  input  WIDTH  operand B, captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result and flags valid from this cycle on.
- result  output  WIDTH  low result (product low half / quotient).
- result_hi  output  WIDTH  high result (product high half / remainder); 0 for other ops.
- carry  output  1  carry out (ADD), borrow (SUB), last bit shifted out (SHL).
- zero  output  1  result == 0 (and result_hi == 0 for MUL).
- ovf  output  1  signed overflow (ADD/SUB) or divide-by-zero (DIV).

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset: FSM to IDLE; busy, done, result, result_hi, carry, zero, ovf all 0; iteration counter 0.
- FSM states:
  - IDLE: start=1 captures op/a/b, goes to EXEC1 (single-cycle ops) or ITER (MUL/DIV).
  - EXEC1: computes, goes to DONE.
  - ITER: runs exactly WIDTH iterations, then goes to DONE.
  - DONE: asserts done for one cycle, returns to IDLE.
- Latency (start edge to done pulse): 2 cycles for single-cycle ops; WIDTH+2 cycles for MUL/DIV. busy is high in EXEC1/ITER/DONE.
- Opcodes:
  - 000 ADD: {carry,result}=a+b.
  - 001 SUB: result=a-b, carry=borrow (a<b).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: result=a<<b[SHW-1:0], carry=last bit shifted out; shift amount 0 gives carry=0.
  - 110 MUL: unsigned, {result_hi,result}=a*b, one shift-add step per cycle.
  - 111 DIV: unsigned restoring, result=quotient, result_hi=remainder, one step per cycle.
- ovf:
  - ADD/SUB: two's-complement signed overflow.
  - DIV with b=0: ovf=1, result={WIDTH{1}}, result_hi=a; still takes WIDTH+2 cycles.
  - All other ops: 0.
- Outputs are registered and hold their last values until the next done; they are not cleared on a new start.
- start while busy=1: ignored, with no effect on the operation in flight.
- start in the DONE cycle: ignored. The earliest accepted restart is the cycle after done.
- rst asserted mid-operation: aborts on that edge; all outputs return to reset values; no done is produced.
- Operand inputs may change after the start cycle without affecting the operation.

Optional Feature:
- Macro ALU_SAT_EN.
  - Defined: ADD and SUB saturate. ADD overflow gives result={WIDTH{1}}; SUB borrow gives result=0. carry still reports the raw carry/borrow; ovf reports the raw signed overflow.
  - Undefined: ADD/SUB wrap modulo 2^WIDTH.
- No ports change.

Test Plan:
- Reset, then ADD a=8'hF0, b=8'h20 -> done 2 cycles after start; result=8'h10, carry=1, zero=0, ovf=0 (with ALU_SAT_EN: result=8'hFF, carry=1).
- SUB a=8'h80, b=8'h01 -> result=8'h7F, carry=0, ovf=1; SUB a=3, b=3 -> result=0, zero=1.
- MUL a=8'hFF, b=8'hFF -> done exactly 10 cycles after start; result_hi=8'hFE, result=8'h01; busy high for cycles 1..10.
- DIV a=8'd200, b=8'd7 -> result=28, result_hi=4, ovf=0; DIV a=8'd9, b=0 -> result=8'hFF, result_hi=9, ovf=1.
- MUL in flight: pulse start with op=ADD at cycle 3 -> ignored, MUL result unchanged; assert rst at cycle 5 -> all outputs 0, no done pulse.
- SHL a=8'b1000_0001, b=1 -> result=8'h02, carry=1; back-to-back start the cycle after done is accepted.
